// File: rtl/req_rdy_mon_pkg.sv
// Shared definitions for the REQ/RDY/VALID protocol monitor.
package req_rdy_mon_pkg;

   localparam int unsigned NUM_CODES = 8;

   localparam int unsigned ERR_REQ_RISE_NOT_RDY   = 0;
   localparam int unsigned ERR_REQ_AFTER_RDY_FALL = 1;
   localparam int unsigned ERR_RDY_AFTER_REQ_RISE = 2;
   localparam int unsigned ERR_RDY_IDLE_UNSTABLE  = 3;
   localparam int unsigned ERR_REQ_UNSTABLE       = 4;
   localparam int unsigned ERR_ADDR_MISALIGNED    = 5;
   localparam int unsigned ERR_VALID_ILLEGAL      = 6;
   localparam int unsigned ERR_BEAT_MISMATCH      = 7;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BUSY
   } ch_state_t;

endpackage

// File: rtl/req_rdy_protocol_monitor_ch_checker.sv
// Single-channel checker: history registers, transfer FSM, beat counter and
// the unmasked per-cycle error vector.
module req_rdy_ch_checker
   import req_rdy_mon_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LEN_W       = 8,
   parameter int unsigned ALIGN_BYTES = 4
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 prev_ok,
   input  logic                 req,
   input  logic                 rdy,
   input  logic                 wen,
   input  logic                 valid,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [LEN_W-1:0]     len,
   output logic [NUM_CODES-1:0] err
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(ALIGN_BYTES - 1);

   logic              req_q, rdy_q, wen_q;
   logic              rdy_fell_q, req_rose_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_lat, len_lat_nx;
   logic [LEN_W:0]    beats, beats_nx;
   ch_state_t         state, state_nx;
   logic              rdy_fall, rdy_rise, burst_close;

   assign rdy_fall = prev_ok & rdy_q & ~rdy;
   assign rdy_rise = prev_ok & ~rdy_q & rdy;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         req_q      <= 1'b0;
         rdy_q      <= 1'b0;
         wen_q      <= 1'b0;
         rdy_fell_q <= 1'b0;
         req_rose_q <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         len_lat    <= '0;
         beats      <= '0;
         state      <= IDLE;
      end else begin
         req_q      <= req;
         rdy_q      <= rdy;
         wen_q      <= wen;
         rdy_fell_q <= rdy_fall;
         req_rose_q <= prev_ok & req & ~req_q;
         addr_q     <= addr;
         len_q      <= len;
         len_lat    <= len_lat_nx;
         beats      <= beats_nx;
         state      <= state_nx;
      end
   end

   // The request is sampled from the cycle before RDY fell, as the slave accepted it then.
   always_comb begin
      state_nx    = state;
      len_lat_nx  = len_lat;
      beats_nx    = beats;
      burst_close = 1'b0;
      case (state)
         IDLE: begin
            if (rdy_fall) begin
               if (wen_q) begin
                  state_nx = WR_BUSY;
               end else begin
                  state_nx   = RD_BURST;
                  len_lat_nx = len_q;
                  beats_nx   = '0;
               end
            end
         end
         RD_BURST: begin
            if (rdy_rise) begin
               burst_close = 1'b1;
               state_nx    = IDLE;
            end else if (valid && (beats != '1)) begin
               beats_nx = beats + 1'b1;
            end
         end
         WR_BUSY: begin
            if (rdy_rise) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      err = '0;
      err[ERR_REQ_RISE_NOT_RDY]   = prev_ok & req & ~req_q & ~rdy_q;
      err[ERR_REQ_AFTER_RDY_FALL] = rdy_fell_q & req;
      err[ERR_RDY_AFTER_REQ_RISE] = req_rose_q & rdy;
      err[ERR_RDY_IDLE_UNSTABLE]  = prev_ok & rdy_q & ~req_q & (rdy != rdy_q);
      err[ERR_REQ_UNSTABLE]       = prev_ok & req_q & req &
                                    ((addr != addr_q) | (len != len_q) | (wen != wen_q));
      err[ERR_ADDR_MISALIGNED]    = req & ((addr & ALIGN_MASK) != '0);
      err[ERR_VALID_ILLEGAL]      = valid & (rdy | rdy_fall | (state != RD_BURST));
      err[ERR_BEAT_MISMATCH]      = burst_close &
                                    ((beats != {1'b0, len_lat}) | (len_lat == '0));
   end

endmodule

// File: rtl/req_rdy_protocol_monitor.sv
// Multi-channel REQ/RDY/VALID protocol monitor with sticky per-channel error
// bits and a timestamped first-error record.
module req_rdy_protocol_monitor
   import req_rdy_mon_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 2,
   parameter  int unsigned ADDR_W      = 32,
   parameter  int unsigned LEN_W       = 8,
   parameter  int unsigned ALIGN_BYTES = 4,
   parameter  int unsigned TS_W        = 32,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          EN,
   input  logic                          CLR,
   input  logic [NUM_CH-1:0]             CH_REQ,
   input  logic [NUM_CH-1:0]             CH_RDY,
   input  logic [NUM_CH-1:0]             CH_WEN,
   input  logic [NUM_CH-1:0]             CH_VALID,
   input  logic [NUM_CH*ADDR_W-1:0]      CH_ADDR,
   input  logic [NUM_CH*LEN_W-1:0]       CH_LEN,
   output logic [NUM_CH*NUM_CODES-1:0]   ERR_STICKY,
   output logic                          ERR_ANY,
   output logic                          FIRST_ERR_VALID,
   output logic [CH_W-1:0]               FIRST_ERR_CH,
   output logic [2:0]                    FIRST_ERR_CODE,
   output logic [TS_W-1:0]               FIRST_ERR_TIME
);

   logic [NUM_CH*NUM_CODES-1:0] raw_err, det, sticky_nx;
   logic                        prev_ok;
   logic [TS_W-1:0]             ts;
   logic                        hit;
   logic [CH_W-1:0]             hit_ch;
   logic [2:0]                  hit_code;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      req_rdy_ch_checker #(
         .ADDR_W      (ADDR_W),
         .LEN_W       (LEN_W),
         .ALIGN_BYTES (ALIGN_BYTES)
      ) u_chk (
         .CLK     (CLK),
         .RESET_N (RESET_N),
         .prev_ok (prev_ok),
         .req     (CH_REQ[i]),
         .rdy     (CH_RDY[i]),
         .wen     (CH_WEN[i]),
         .valid   (CH_VALID[i]),
         .addr    (CH_ADDR[i*ADDR_W +: ADDR_W]),
         .len     (CH_LEN[i*LEN_W +: LEN_W]),
         .err     (raw_err[i*NUM_CODES +: NUM_CODES])
      );
   end

   assign det       = EN ? raw_err : '0;
   assign sticky_nx = (CLR ? '0 : ERR_STICKY) | det;

   // Flat index is ch*NUM_CODES+code, so the first set bit is lowest channel, then lowest code.
   always_comb begin
      hit      = 1'b0;
      hit_ch   = '0;
      hit_code = '0;
      for (int unsigned k = 0; k < NUM_CH * NUM_CODES; k++) begin
         if (det[k] && !hit) begin
            hit      = 1'b1;
            hit_ch   = CH_W'(k / NUM_CODES);
            hit_code = 3'(k % NUM_CODES);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         prev_ok         <= 1'b0;
         ts              <= '0;
         ERR_STICKY      <= '0;
         ERR_ANY         <= 1'b0;
         FIRST_ERR_VALID <= 1'b0;
         FIRST_ERR_CH    <= '0;
         FIRST_ERR_CODE  <= '0;
         FIRST_ERR_TIME  <= '0;
      end else begin
         prev_ok    <= 1'b1;
         ts         <= ts + 1'b1;
         ERR_STICKY <= sticky_nx;
         ERR_ANY    <= |sticky_nx;
         if ((CLR || !FIRST_ERR_VALID) && hit) begin
            FIRST_ERR_VALID <= 1'b1;
            FIRST_ERR_CH    <= hit_ch;
            FIRST_ERR_CODE  <= hit_code;
            FIRST_ERR_TIME  <= ts;
         end else if (CLR) begin
            FIRST_ERR_VALID <= 1'b0;
            FIRST_ERR_CH    <= '0;
            FIRST_ERR_CODE  <= '0;
            FIRST_ERR_TIME  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_req_rdy_protocol_monitor.sv
// Directed bench for req_rdy_protocol_monitor with a 4-bit timestamp so wrap is reachable.
module tb_req_rdy_protocol_monitor;

   logic        CLK = 1'b0;
   logic        RESET_N, EN, CLR;
   logic [1:0]  req, rdy, wen, valid;
   logic [63:0] addr;
   logic [15:0] len;
   logic [15:0] err_sticky;
   logic        err_any, fe_valid;
   logic [0:0]  fe_ch;
   logic [2:0]  fe_code;
   logic [3:0]  fe_time;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned ts_m  = 0;
   int unsigned t_err = 0;

   req_rdy_protocol_monitor #(
      .NUM_CH      (2),
      .ADDR_W      (32),
      .LEN_W       (8),
      .ALIGN_BYTES (4),
      .TS_W        (4)
   ) dut (
      .CLK             (CLK),
      .RESET_N         (RESET_N),
      .EN              (EN),
      .CLR             (CLR),
      .CH_REQ          (req),
      .CH_RDY          (rdy),
      .CH_WEN          (wen),
      .CH_VALID        (valid),
      .CH_ADDR         (addr),
      .CH_LEN          (len),
      .ERR_STICKY      (err_sticky),
      .ERR_ANY         (err_any),
      .FIRST_ERR_VALID (fe_valid),
      .FIRST_ERR_CH    (fe_ch),
      .FIRST_ERR_CODE  (fe_code),
      .FIRST_ERR_TIME  (fe_time)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // ts_m tracks the DUT timestamp value for the cycle whose inputs are currently driven.
   task automatic step();
      @(posedge CLK);
      ts_m = RESET_N ? (ts_m + 1) % 16 : 0;
      #1;
   endtask

   task automatic idle();
      req   = '0;
      rdy   = '1;
      wen   = '0;
      valid = '0;
      addr  = {32'h100, 32'h100};
      len   = {8'd4, 8'd4};
      CLR   = 1'b0;
   endtask

   task automatic set_ch(input int ch, input logic r, input logic y, input logic w,
                         input logic v, input logic [31:0] a);
      req[ch]             = r;
      rdy[ch]             = y;
      wen[ch]             = w;
      valid[ch]           = v;
      addr[ch*32 +: 32]   = a;
   endtask

   initial begin
      idle();
      EN      = 1'b1;
      RESET_N = 1'b0;
      step();
      step();
      chk("rst_sticky", 32'(err_sticky), 0);
      chk("rst_any", 32'(err_any), 0);
      chk("rst_fvalid", 32'(fe_valid), 0);
      chk("rst_ftime", 32'(fe_time), 0);

      RESET_N = 1'b1;
      repeat (3) step();
      chk("idle_any", 32'(err_any), 0);

      // legal read, LEN=4, 4 beats on channel 0
      set_ch(0, 1, 1, 0, 0, 32'h100); step();
      set_ch(0, 1, 0, 0, 0, 32'h100); step();
      set_ch(0, 0, 0, 0, 1, 32'h100); repeat (4) step();
      set_ch(0, 0, 1, 0, 0, 32'h100); step();
      chk("legal_rd_any", 32'(err_any), 0);
      idle(); step();
      chk("legal_rd_fvalid", 32'(fe_valid), 0);

      // short read, 3 beats on channel 1
      set_ch(1, 1, 1, 0, 0, 32'h100); step();
      set_ch(1, 1, 0, 0, 0, 32'h100); step();
      set_ch(1, 0, 0, 0, 1, 32'h100); repeat (3) step();
      chk("short_pre_any", 32'(err_any), 0);
      set_ch(1, 0, 1, 0, 0, 32'h100); t_err = ts_m; step();
      chk("short_sticky", 32'(err_sticky), 32'h8000);
      chk("short_any", 32'(err_any), 1);
      chk("short_ch", 32'(fe_ch), 1);
      chk("short_code", 32'(fe_code), 7);
      chk("short_time", 32'(fe_time), t_err);

      idle(); CLR = 1'b1; step(); idle();
      chk("clr_sticky", 32'(err_sticky), 0);
      chk("clr_any", 32'(err_any), 0);
      chk("clr_fvalid", 32'(fe_valid), 0);

      // ch0 misaligned and ch1 REQ after RDY fall in the same cycle
      set_ch(1, 1, 1, 0, 0, 32'h100); step();
      set_ch(1, 1, 0, 0, 0, 32'h100); step();
      set_ch(1, 1, 0, 0, 0, 32'h100);
      set_ch(0, 1, 1, 0, 0, 32'h102); step();
      chk("tie_sticky", 32'(err_sticky), 32'h0220);
      chk("tie_ch", 32'(fe_ch), 0);
      chk("tie_code", 32'(fe_code), 5);
      set_ch(0, 0, 1, 0, 0, 32'h100);
      set_ch(1, 0, 0, 0, 0, 32'h100); step();

      // reset while channel 1 is mid-burst
      RESET_N = 1'b0; idle(); step();
      chk("midrst_sticky", 32'(err_sticky), 0);
      chk("midrst_fvalid", 32'(fe_valid), 0);
      RESET_N = 1'b1;
      repeat (4) step();
      chk("midrst_any", 32'(err_any), 0);

      // address change while REQ held (write)
      set_ch(0, 1, 1, 1, 0, 32'h100); step();
      set_ch(0, 1, 0, 1, 0, 32'h104); step();
      chk("unstable_sticky", 32'(err_sticky), 32'h0010);
      chk("unstable_code", 32'(fe_code), 4);
      set_ch(0, 0, 0, 1, 0, 32'h100); step();
      set_ch(0, 0, 1, 0, 0, 32'h100); step();
      chk("unstable_only", 32'(err_sticky), 32'h0010);
      idle(); CLR = 1'b1; step(); idle();

      // same sequence with checking disabled
      EN = 1'b0;
      set_ch(0, 1, 1, 1, 0, 32'h100); step();
      set_ch(0, 1, 0, 1, 0, 32'h104); step();
      set_ch(0, 0, 0, 1, 0, 32'h100); step();
      set_ch(0, 0, 1, 0, 0, 32'h100); step();
      chk("en0_sticky", 32'(err_sticky), 0);
      chk("en0_fvalid", 32'(fe_valid), 0);
      EN = 1'b1;
      idle(); step();

      // error at timestamp 15, then at the wrapped value 0
      while (ts_m != 15) step();
      set_ch(0, 1, 1, 0, 0, 32'h102); step();
      chk("wrap_time", 32'(fe_time), 15);
      chk("wrap_code", 32'(fe_code), 5);
      CLR = 1'b1; step(); CLR = 1'b0;
      chk("wrap0_time", 32'(fe_time), 0);
      chk("wrap0_code", 32'(fe_code), 2);
      chk("wrap0_sticky", 32'(err_sticky), 32'h0024);
      set_ch(0, 0, 1, 0, 0, 32'h100); step();
      idle(); CLR = 1'b1; step(); idle();

      // CLR colliding with a VALID-while-RDY error
      set_ch(1, 0, 1, 0, 1, 32'h100); step();
      chk("pre_sticky", 32'(err_sticky), 32'h4000);
      chk("pre_ch", 32'(fe_ch), 1);
      chk("pre_code", 32'(fe_code), 6);
      idle();
      set_ch(0, 0, 1, 0, 1, 32'h100); CLR = 1'b1; t_err = ts_m; step();
      idle();
      chk("clr6_sticky", 32'(err_sticky), 32'h0040);
      chk("clr6_fvalid", 32'(fe_valid), 1);
      chk("clr6_ch", 32'(fe_ch), 0);
      chk("clr6_code", 32'(fe_code), 6);
      chk("clr6_time", 32'(fe_time), t_err);
      step();
      chk("hold_sticky", 32'(err_sticky), 32'h0040);
      chk("hold_any", 32'(err_any), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
